// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute states and
// drives datapath mux selects plus memory and register-file strobes.
module mc_control_fsm #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02,
  parameter logic [5:0] OP_ADDI  = 6'h08
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_e;

  state_e state_q, state_d;

  assign state = state_q;

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore outputs; selects follow the state, strobes may also
  // follow mem_ready in the memory-wait states. Reset masks every output.
  always_comb begin
    state_d       = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        if (opcode == OP_LW || opcode == OP_SW) begin
          state_d = S_MEMADR;
        end else if (opcode == OP_RTYPE) begin
          state_d = S_EXEC;
        end else if (opcode == OP_BEQ) begin
          state_d = S_BRANCH;
        end else if (opcode == OP_J) begin
          state_d = S_JUMP;
        end else if (opcode == OP_ADDI) begin
          state_d = S_ADDIEX;
        end else begin
          illegal_op = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_LW) begin
          state_d = S_MEMRD;
        end else if (opcode == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        state_d  = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
        state_d    = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class, memory
// wait states, an illegal opcode and a mid-instruction reset.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic       instr_done, illegal_op;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctl_t;

  ctl_t obs;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .state         (state),
    .instr_done    (instr_done),
    .illegal_op    (illegal_op)
  );

  assign obs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_source, instr_done, illegal_op};

  // Expected output sets, transcribed from the per-state encoding table.
  function automatic ctl_t e_fetch(input logic rdy);
    ctl_t c = '0;
    c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy;
    return c;
  endfunction
  function automatic ctl_t e_decode(input logic bad);
    ctl_t c = '0;
    c.alu_src_b = 2'b11; c.illegal_op = bad;
    return c;
  endfunction
  function automatic ctl_t e_memadr();
    ctl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
    return c;
  endfunction
  function automatic ctl_t e_memrd();
    ctl_t c = '0;
    c.iord = 1'b1; c.mem_read = 1'b1;
    return c;
  endfunction
  function automatic ctl_t e_memwb();
    ctl_t c = '0;
    c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1;
    return c;
  endfunction
  function automatic ctl_t e_memwr(input logic rdy);
    ctl_t c = '0;
    c.iord = 1'b1; c.mem_write = 1'b1; c.instr_done = rdy;
    return c;
  endfunction
  function automatic ctl_t e_exec();
    ctl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_op = 2'b10;
    return c;
  endfunction
  function automatic ctl_t e_aluwb();
    ctl_t c = '0;
    c.reg_dst = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1;
    return c;
  endfunction
  function automatic ctl_t e_branch();
    ctl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1;
    c.pc_source = 2'b01; c.instr_done = 1'b1;
    return c;
  endfunction
  function automatic ctl_t e_jump();
    ctl_t c = '0;
    c.pc_write = 1'b1; c.pc_source = 2'b10; c.instr_done = 1'b1;
    return c;
  endfunction
  function automatic ctl_t e_addiex();
    ctl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
    return c;
  endfunction
  function automatic ctl_t e_addiwb();
    ctl_t c = '0;
    c.reg_write = 1'b1; c.instr_done = 1'b1;
    return c;
  endfunction

  // Compare state and all outputs mid-cycle, then advance past the next edge.
  task automatic chk(input string tag, input logic [3:0] exp_st, input ctl_t exp_c);
    @(negedge clk);
    vectors++;
    assert ({state, obs} === {exp_st, exp_c}) else begin
      miscompares++;
      $error("FAIL %s: observed state=%0d ctl=%05h, expected state=%0d ctl=%05h",
             tag, state, obs, exp_st, exp_c);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    opcode    = 6'h00;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset holds everything at 0 even with mem_ready high
    chk("rst_cyc0", 4'd0, '0);
    chk("rst_cyc1", 4'd0, '0);
    rst    = 1'b0;
    opcode = 6'h23;
    chk("fetch_after_rst", 4'd0, e_fetch(1'b1));

    // LW with immediate memory: 0,1,2,3,4,0
    chk("lw_decode", 4'd1, e_decode(1'b0));
    chk("lw_memadr", 4'd2, e_memadr());
    chk("lw_memrd",  4'd3, e_memrd());
    chk("lw_memwb",  4'd4, e_memwb());

    // SW with three wait cycles in MEMWR
    opcode = 6'h2B;
    chk("sw_fetch",  4'd0, e_fetch(1'b1));
    chk("sw_decode", 4'd1, e_decode(1'b0));
    mem_ready = 1'b0;
    chk("sw_memadr", 4'd2, e_memadr());
    chk("sw_wait0",  4'd5, e_memwr(1'b0));
    chk("sw_wait1",  4'd5, e_memwr(1'b0));
    chk("sw_wait2",  4'd5, e_memwr(1'b0));
    mem_ready = 1'b1;
    chk("sw_done",   4'd5, e_memwr(1'b1));

    // Fetch stall: request held, no strobes, state held
    mem_ready = 1'b0;
    opcode    = 6'h00;
    chk("fetch_wait", 4'd0, e_fetch(1'b0));
    mem_ready = 1'b1;
    chk("rt_fetch",   4'd0, e_fetch(1'b1));
    chk("rt_decode",  4'd1, e_decode(1'b0));
    chk("rt_exec",    4'd6, e_exec());
    chk("rt_aluwb",   4'd7, e_aluwb());

    // BEQ
    opcode = 6'h04;
    chk("beq_fetch",  4'd0, e_fetch(1'b1));
    chk("beq_decode", 4'd1, e_decode(1'b0));
    chk("beq_branch", 4'd8, e_branch());

    // J
    opcode = 6'h02;
    chk("j_fetch",  4'd0, e_fetch(1'b1));
    chk("j_decode", 4'd1, e_decode(1'b0));
    chk("j_jump",   4'd9, e_jump());

    // ADDI
    opcode = 6'h08;
    chk("addi_fetch",  4'd0, e_fetch(1'b1));
    chk("addi_decode", 4'd1, e_decode(1'b0));
    chk("addi_ex",     4'd10, e_addiex());
    chk("addi_wb",     4'd11, e_addiwb());

    // Illegal opcode: single pulse in DECODE, back to FETCH
    opcode = 6'h3F;
    chk("ill_fetch",  4'd0, e_fetch(1'b1));
    chk("ill_decode", 4'd1, e_decode(1'b1));
    opcode = 6'h23;
    chk("ill_return", 4'd0, e_fetch(1'b1));

    // Reset while LW waits in MEMRD
    chk("rlw_decode", 4'd1, e_decode(1'b0));
    mem_ready = 1'b0;
    chk("rlw_memadr", 4'd2, e_memadr());
    chk("rlw_memrd",  4'd3, e_memrd());
    rst = 1'b1;
    chk("rlw_rst_in_memrd", 4'd3, '0);
    chk("rlw_rst_hold",     4'd0, '0);
    rst       = 1'b0;
    mem_ready = 1'b1;
    chk("rlw_clean_fetch",  4'd0, e_fetch(1'b1));
    chk("rlw_clean_decode", 4'd1, e_decode(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
